// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction field positions, reset PC
// and the fetch buffer entry layout.
package mips_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    localparam logic [INSTR_W-1:0] NOP      = '0;
    localparam logic [31:0]        RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_entry_t;

    // Sequential word address, wrapping at 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order queue of fetched {instr, pc} entries with synchronous
// clear. DEPTH must be a power of two so the pointers wrap naturally.
// The head reads as all-zero while the queue is empty.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   occ_o,
    output logic                         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   occ_q;
    logic            do_push, do_pop;

    assign do_pop  = pop_i && (occ_q != '0);
    assign do_push = push_i && ((occ_q != FULL) || do_pop);

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage array, no reset needed since the head is gated when empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;
    assign head_o  = empty_o ? '{instr: NOP, pc: '0} : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, issues in-order word reads to instruction
// memory and buffers returned words for decode. Redirects flush the stage;
// halt only blocks new requests.
// Optional build macro IFETCH_PERF_EN adds perf_fetched / perf_stall counters.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occ;
    logic [CW:0]   credit;
    logic          accept, pop, push, empty;
    fetch_entry_t  head, push_entry;

    // A head popped this cycle frees its slot, which keeps single-cycle
    // memory at one instruction per cycle; total still never exceeds DEPTH.
    assign pop      = id_valid && id_ready;
    assign credit   = {1'b0, inflight_q} + {1'b0, occ} - {{CW{1'b0}}, pop};
    assign imem_req_valid = !rst && !halt && !redirect_valid && (credit < DEPTH_L);
    assign imem_req_addr  = pc_q;
    assign accept   = imem_req_valid && imem_req_ready;

    // Responses are in order, so the oldest live request is always rsp_pc_q.
    assign push       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

    // Next-state for PC, response-PC tracker and the two counters.
    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q;
        if (accept)         inflight_d = inflight_d + 1'b1;
        if (imem_rsp_valid) inflight_d = inflight_d - 1'b1;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rsp_pc_d = {redirect_pc[31:2], 2'b00};
            // inflight already includes words pending drop, so every
            // request still outstanding after this cycle becomes stale.
            drop_d   = inflight_d;
        end else begin
            if (accept) pc_d = pc_plus4(pc_q);
            if (imem_rsp_valid) begin
                if (drop_q != '0) drop_d   = drop_q - 1'b1;
                else              rsp_pc_d = pc_plus4(rsp_pc_q);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .occ_o       (occ),
        .empty_o     (empty)
    );

    assign id_valid    = !empty;
    assign id_instr    = head.instr;
    assign id_pc       = head.pc;
    assign id_pc_plus4 = empty ? '0 : pc_plus4(head.pc);
    assign id_opcode   = head.instr[OPCODE_MSB:OPCODE_LSB];
    assign id_funct    = head.instr[FUNCT_MSB:FUNCT_LSB];

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    // Count buffered instructions and request-stall cycles, wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push)                             perf_fetched_q <= perf_fetched_q + 32'd1;
            if (imem_req_valid && !imem_req_ready) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
